commit_trace_buffer: RTL and testbench

Write-back commit monitor that sits directly downstream of the pipelined CPU top. It consumes the CPU's retirement outputs (ResultW, RegWriteW, RdW) and turns every qualifying register-file write into a tagged trace record. Records are queued in a FIFO and drained over a valid/ready stream to a testbench scoreboard or debug port. Overflow is reported and counted, never silent.

---
 rtl/commit_trace_buffer.sv | 129 ++++++++++++
 tb/tb_commit_trace_buffer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Write-back commit monitor: turns every qualifying register-file write from the
// CPU retirement stage into a tagged trace record. Records are queued in a FIFO
// with a first-word-fall-through head register and drained over valid/ready.
// Dropped commits are counted; they still consume a sequence tag.
module commit_trace_buffer #(
  parameter int DEPTH     = 8,
  parameter int SEQ_W     = 16,
  parameter int DROP_W    = 8,
  parameter int FILTER_X0 = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trace_en,
  input  logic                     clear,
  input  logic                     RegWriteW,
  input  logic [4:0]               RdW,
  input  logic [31:0]              ResultW,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [SEQ_W-1:0]         trace_seq,
  output logic [4:0]               trace_rd,
  output logic [31:0]              trace_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [4:0]       rd;
    logic [31:0]      data;
  } rec_t;

  rec_t              mem_q [DEPTH];
  rec_t              head_q, head_d;
  rec_t              new_rec;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CNT_W-1:0]  count_q, count_d, cnt_after_pop;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              overflow_q, overflow_d;
  logic              qual, empty, full, pop, push, drop, mem_we;

  // Next-state computation: qualification, push/pop/drop decisions, head prefetch
  always_comb begin
    qual          = trace_en && RegWriteW && !((FILTER_X0 != 0) && (RdW == 5'd0));
    empty         = (count_q == '0);
    full          = (count_q == CNT_W'(DEPTH));
    pop           = !empty && trace_ready;
    // A full FIFO still accepts a commit when the head leaves on the same edge
    push          = qual && (!full || pop);
    drop          = qual && full && !pop;
    new_rec       = '{seq: seq_q, rd: RdW, data: ResultW};
    cnt_after_pop = count_q - CNT_W'(pop);
    rd_nxt        = rd_ptr_q + PTR_W'(pop);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    head_d     = head_q;
    mem_we     = 1'b0;

    if (clear) begin
      // Flush wins over any commit or pop this cycle; head value is don't-care
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      seq_d      = '0;
      drop_d     = '0;
      overflow_d = 1'b0;
    end else begin
      mem_we   = push;
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_nxt;
      count_d  = cnt_after_pop + CNT_W'(push);
      // Dropped commits also advance the tag so gaps reveal losses
      if (qual) seq_d = seq_q + 1'b1;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + 1'b1;
      end
      // Head is the next stored entry, or the incoming record if the FIFO drains
      // to empty this edge; otherwise it keeps its last value
      if (cnt_after_pop != '0) head_d = mem_q[rd_nxt];
      else if (push)           head_d = new_rec;
    end
  end

  // Control and head state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      head_q     <= head_d;
    end
  end

  // Record storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= new_rec;
  end

  assign trace_valid = (count_q != '0);
  assign trace_seq   = head_q.seq;
  assign trace_rd    = head_q.rd;
  assign trace_data  = head_q.data;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: ordering, x0 filtering, overflow and
// drop saturation, full push-with-pop, backpressure, seq wrap, clear and reset.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trace_en = 1'b0;
  logic        clear = 1'b0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  RdW = '0;
  logic [31:0] ResultW = '0;
  logic        trace_ready = 1'b0;

  logic        trace_valid, overflow;
  logic [15:0] trace_seq;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;
  logic [3:0]  fifo_count;
  logic [7:0]  drop_count;

  logic        nf_valid, nf_overflow;
  logic [15:0] nf_seq;
  logic [4:0]  nf_rd;
  logic [31:0] nf_data;
  logic [3:0]  nf_count;
  logic [7:0]  nf_drop;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(8), .SEQ_W(16), .DROP_W(8), .FILTER_X0(1)) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en), .clear(clear),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_seq(trace_seq), .trace_rd(trace_rd), .trace_data(trace_data),
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count));

  commit_trace_buffer #(.DEPTH(8), .SEQ_W(16), .DROP_W(8), .FILTER_X0(0)) dut_nf (
    .clk(clk), .reset(reset), .trace_en(trace_en), .clear(clear),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .trace_valid(nf_valid), .trace_ready(trace_ready),
    .trace_seq(nf_seq), .trace_rd(nf_rd), .trace_data(nf_data),
    .fifo_count(nf_count), .overflow(nf_overflow), .drop_count(nf_drop));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", trace_valid); end
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
    checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d want=0", drop_count); end
    checks++; if ({trace_seq, trace_rd, trace_data} !== 53'd0) begin failures++;
      $display("FAIL reset_head got=%h/%h/%h want=0/0/0", trace_seq, trace_rd, trace_data); end
    reset = 1'b1;
    trace_en = 1'b1;
    step();
  endtask

  task automatic test_basic();
    do_clear();
    trace_ready = 1'b1;
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h11;
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL basic_pre_valid got=%0b want=0", trace_valid); end
    step();
    checks++; if ({trace_valid, trace_seq, trace_rd, trace_data} !== {1'b1, 16'd0, 5'd5, 32'h11}) begin failures++;
      $display("FAIL basic_rec0 got=%0b/%h/%0d/%h want=1/0000/5/00000011", trace_valid, trace_seq, trace_rd, trace_data); end
    RdW = 5'd6; ResultW = 32'h22;
    step();
    checks++; if ({trace_valid, trace_seq, trace_rd, trace_data} !== {1'b1, 16'd1, 5'd6, 32'h22}) begin failures++;
      $display("FAIL basic_rec1 got=%0b/%h/%0d/%h want=1/0001/6/00000022", trace_valid, trace_seq, trace_rd, trace_data); end
    RdW = 5'd7; ResultW = 32'h33;
    step();
    checks++; if ({trace_valid, trace_seq, trace_rd, trace_data} !== {1'b1, 16'd2, 5'd7, 32'h33}) begin failures++;
      $display("FAIL basic_rec2 got=%0b/%h/%0d/%h want=1/0002/7/00000033", trace_valid, trace_seq, trace_rd, trace_data); end
    RegWriteW = 1'b0;
    step();
    checks++; if ({trace_valid, fifo_count} !== {1'b0, 4'd0}) begin failures++;
      $display("FAIL basic_drained got=%0b/%0d want=0/0", trace_valid, fifo_count); end
    trace_ready = 1'b0;
  endtask

  task automatic test_x0_filter();
    do_clear();
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hDEAD;
    step();
    RdW = 5'd1; ResultW = 32'h1;
    step();
    RegWriteW = 1'b0;
    checks++; if ({fifo_count, trace_valid, trace_seq, trace_rd, trace_data} !== {4'd1, 1'b1, 16'd0, 5'd1, 32'h1}) begin failures++;
      $display("FAIL x0_filtered got=%0d/%0b/%h/%0d/%h want=1/1/0000/1/00000001", fifo_count, trace_valid, trace_seq, trace_rd, trace_data); end
    checks++; if ({nf_count, nf_valid, nf_seq, nf_rd, nf_data} !== {4'd2, 1'b1, 16'd0, 5'd0, 32'hDEAD}) begin failures++;
      $display("FAIL x0_unfiltered_rec0 got=%0d/%0b/%h/%0d/%h want=2/1/0000/0/0000dead", nf_count, nf_valid, nf_seq, nf_rd, nf_data); end
    trace_ready = 1'b1;
    step();
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL x0_filtered_empty got=%0b want=0", trace_valid); end
    checks++; if ({nf_valid, nf_seq, nf_rd, nf_data} !== {1'b1, 16'd1, 5'd1, 32'h1}) begin failures++;
      $display("FAIL x0_unfiltered_rec1 got=%0b/%h/%0d/%h want=1/0001/1/00000001", nf_valid, nf_seq, nf_rd, nf_data); end
    step();
    trace_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 10; i++) begin
      RegWriteW = 1'b1; RdW = 5'(i + 1); ResultW = 32'h100 + 32'(i);
      step();
    end
    RegWriteW = 1'b0;
    checks++; if ({fifo_count, overflow, drop_count} !== {4'd8, 1'b1, 8'd2}) begin failures++;
      $display("FAIL ovf_state got=%0d/%0b/%0d want=8/1/2", fifo_count, overflow, drop_count); end
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if ({trace_valid, trace_seq, trace_rd, trace_data} !== {1'b1, 16'(i), 5'(i + 1), 32'h100 + 32'(i)}) begin failures++;
        $display("FAIL ovf_drain%0d got=%0b/%h/%0d/%h want=1/%h/%0d/%h", i, trace_valid, trace_seq, trace_rd, trace_data, 16'(i), i + 1, 32'h100 + 32'(i)); end
      step();
    end
    trace_ready = 1'b0;
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0b want=0", trace_valid); end
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hAA;
    step();
    RegWriteW = 1'b0;
    checks++; if ({trace_valid, trace_seq} !== {1'b1, 16'd10}) begin failures++;
      $display("FAIL ovf_next_seq got=%0b/%0d want=1/10", trace_valid, trace_seq); end
  endtask

  task automatic test_drop_saturate();
    do_clear();
    RegWriteW = 1'b1; RdW = 5'd2;
    for (int i = 0; i < 8 + 260; i++) begin
      ResultW = 32'(i);
      step();
    end
    RegWriteW = 1'b0;
    checks++; if ({fifo_count, overflow, drop_count} !== {4'd8, 1'b1, 8'hFF}) begin failures++;
      $display("FAIL drop_saturate got=%0d/%0b/%0d want=8/1/255", fifo_count, overflow, drop_count); end
  endtask

  task automatic test_full_pop();
    do_clear();
    RegWriteW = 1'b1; RdW = 5'd2;
    for (int i = 0; i < 8; i++) begin
      ResultW = 32'(i);
      step();
    end
    checks++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL fullpop_fill got=%0d want=8", fifo_count); end
    ResultW = 32'h99; trace_ready = 1'b1;
    step();
    RegWriteW = 1'b0; trace_ready = 1'b0;
    checks++; if ({fifo_count, overflow, drop_count, trace_seq} !== {4'd8, 1'b0, 8'd0, 16'd1}) begin failures++;
      $display("FAIL fullpop_state got=%0d/%0b/%0d/%0d want=8/0/0/1", fifo_count, overflow, drop_count, trace_seq); end
  endtask

  task automatic test_backpressure();
    logic [52:0] exp_q[$];
    logic [52:0] exp_rec, head, prev_head;
    logic [15:0] nseq;
    logic        prev_stall;
    int          pushed, cycles;
    do_clear();
    nseq = '0; pushed = 0; cycles = 0; prev_stall = 1'b0; prev_head = '0;
    while ((pushed < 200 || exp_q.size() != 0) && cycles < 3000) begin
      head = {trace_seq, trace_rd, trace_data};
      if (prev_stall) begin
        checks++; if (head !== prev_head) begin failures++;
          $display("FAIL bp_stable got=%h want=%h", head, prev_head); end
      end
      trace_ready = 1'($urandom_range(0, 1));
      if (trace_valid && trace_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL bp_unexpected got=%h want=none", head); end
        else begin
          exp_rec = exp_q.pop_front();
          if (head !== exp_rec) begin failures++; $display("FAIL bp_record got=%h want=%h", head, exp_rec); end
        end
      end
      if (pushed < 200 && fifo_count < 4'd8 && $urandom_range(0, 3) != 0) begin
        RegWriteW = 1'b1; RdW = 5'($urandom_range(1, 31)); ResultW = $urandom;
        exp_q.push_back({nseq, RdW, ResultW});
        nseq++; pushed++;
      end else begin
        RegWriteW = 1'b0;
      end
      prev_stall = trace_valid && !trace_ready;
      prev_head = head;
      step();
      cycles++;
    end
    RegWriteW = 1'b0; trace_ready = 1'b0;
    checks++; if (cycles >= 3000 || exp_q.size() != 0) begin failures++;
      $display("FAIL bp_complete got=cycles %0d left %0d want=all drained", cycles, exp_q.size()); end
  endtask

  task automatic test_seq_wrap();
    int errs;
    logic [15:0] s_ff, s_00;
    do_clear();
    errs = 0; s_ff = '0; s_00 = 16'hBEEF;
    trace_ready = 1'b1; RegWriteW = 1'b1; RdW = 5'd4;
    for (int k = 0; k < 65538; k++) begin
      ResultW = 32'(k);
      step();
      if (trace_seq !== 16'(k) || trace_valid !== 1'b1) errs++;
      if (k == 65535) s_ff = trace_seq;
      if (k == 65536) s_00 = trace_seq;
    end
    RegWriteW = 1'b0;
    step();
    trace_ready = 1'b0;
    checks++; if (errs != 0) begin failures++; $display("FAIL wrap_stream got=%0d bad want=0", errs); end
    checks++; if (s_ff !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%h want=ffff", s_ff); end
    checks++; if (s_00 !== 16'h0000) begin failures++; $display("FAIL wrap_0000 got=%h want=0000", s_00); end
  endtask

  task automatic test_clear_reset();
    do_clear();
    RegWriteW = 1'b1; RdW = 5'd8;
    for (int i = 0; i < 9; i++) begin
      ResultW = 32'(i);
      step();
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL clr_pre_ovf got=%0b want=1", overflow); end
    clear = 1'b1;
    step();
    clear = 1'b0; RegWriteW = 1'b0;
    checks++; if ({fifo_count, trace_valid, overflow, drop_count} !== {4'd0, 1'b0, 1'b0, 8'd0}) begin failures++;
      $display("FAIL clr_state got=%0d/%0b/%0b/%0d want=0/0/0/0", fifo_count, trace_valid, overflow, drop_count); end
    RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h55;
    step();
    checks++; if ({trace_valid, trace_seq, trace_rd, trace_data} !== {1'b1, 16'd0, 5'd9, 32'h55}) begin failures++;
      $display("FAIL clr_next got=%0b/%h/%0d/%h want=1/0000/9/00000055", trace_valid, trace_seq, trace_rd, trace_data); end
    for (int i = 0; i < 3; i++) step();
    RegWriteW = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if ({trace_valid, fifo_count, trace_seq, trace_rd, trace_data} !== {1'b0, 4'd0, 53'd0}) begin failures++;
      $display("FAIL rst_async got=%0b/%0d/%h/%0d/%h want=0/0/0/0/0", trace_valid, fifo_count, trace_seq, trace_rd, trace_data); end
    reset = 1'b1;
    step();
    RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h77;
    step();
    RegWriteW = 1'b0;
    checks++; if ({trace_valid, trace_seq, trace_rd, trace_data} !== {1'b1, 16'd0, 5'd2, 32'h77}) begin failures++;
      $display("FAIL rst_next got=%0b/%h/%0d/%h want=1/0000/2/00000077", trace_valid, trace_seq, trace_rd, trace_data); end
  endtask

  task automatic test_trace_disable();
    do_clear();
    trace_en = 1'b0; RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h5;
    step();
    trace_en = 1'b1; ResultW = 32'h6;
    step();
    RegWriteW = 1'b0;
    checks++; if ({fifo_count, trace_seq, trace_data} !== {4'd1, 16'd0, 32'h6}) begin failures++;
      $display("FAIL disable got=%0d/%0d/%h want=1/0/00000006", fifo_count, trace_seq, trace_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_x0_filter();
    test_overflow();
    test_drop_saturate();
    test_full_pop();
    test_trace_disable();
    test_backpressure();
    test_seq_wrap();
    test_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
